// File: rtl/samples_ring_buf_nmult.sv
// -----------------------------------------------------------------------------
// samples_ring_buf_nmult
//
// Circular sample store feeding an N-way multiplier array of a FIR datapath.
// Incoming samples are written at an internal write pointer. Each read port is
// addressed by a tap offset counted back from the newest sample (0 = newest),
// so the MAC controller never handles absolute addresses.
//
// The storage array carries no reset. After reset or clear_i, a sweep writes
// zeros to every slot, one per cycle, so the array can map onto FPGA
// block/distributed RAM.
//
// Configuration macro:
//   SAMPLES_RING_BUF_WR_FWD_EN - when defined, a read issued in the same cycle
//       as a write sees the post-write buffer. Offset 0 returns in_data_i,
//       forwarded straight into the read register. When undefined, reads in a
//       write cycle are read-before-write. Without a same-cycle write, both
//       builds behave identically.
//
// Parameters:
//   DataWidth  sample width (signed two's complement, stored bit-exact)
//   AddrWidth  log2 of depth; Depth = 2**AddrWidth
//   NumPorts   number of independent read ports (>= 1)
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   clear_i      synchronous flush request, restarts the zero sweep
//   in_valid_i   input sample valid
//   in_ready_o   buffer accepts a sample (registered, high only in RUN)
//   in_data_i    input sample
//   rd_req_i     read all ports this cycle
//   rd_offset_i  per-port tap offset, port p at [p*AddrWidth +: AddrWidth]
//   rd_valid_o   one-cycle pulse, rd_data_o valid
//   rd_data_o    per-port sample, port p at [p*DataWidth +: DataWidth]
//   fill_o       samples written since last sweep, saturates at Depth
//   full_o       fill_o == Depth
// -----------------------------------------------------------------------------
module samples_ring_buf_nmult #(
    parameter int unsigned DataWidth = 18,
    parameter int unsigned AddrWidth = 7,
    parameter int unsigned NumPorts  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [DataWidth-1:0]          in_data_i,
    input  logic                          rd_req_i,
    input  logic [NumPorts*AddrWidth-1:0] rd_offset_i,
    output logic                          rd_valid_o,
    output logic [NumPorts*DataWidth-1:0] rd_data_o,
    output logic [AddrWidth:0]            fill_o,
    output logic                          full_o
);

    localparam int unsigned Depth = 2 ** AddrWidth;

    localparam logic [AddrWidth-1:0] AddrOne  = AddrWidth'(1'b1);
    localparam logic [AddrWidth-1:0] AddrLast = {AddrWidth{1'b1}};
    localparam logic [AddrWidth:0]   FillOne  = (AddrWidth + 1)'(1'b1);
    localparam logic [AddrWidth:0]   FillMax  = {1'b1, {AddrWidth{1'b0}}};

    typedef enum logic [0:0] {
        StClr = 1'b0,
        StRun = 1'b1
    } state_e;

    // Registered state
    state_e                        state_q,    state_d;
    logic [AddrWidth-1:0]          clr_cnt_q,  clr_cnt_d;
    logic [AddrWidth-1:0]          wr_ptr_q,   wr_ptr_d;
    logic [AddrWidth:0]            fill_q,     fill_d;
    logic                          full_q,     full_d;
    logic                          in_ready_q, in_ready_d;
    logic                          rd_valid_q, rd_valid_d;
    logic [NumPorts*DataWidth-1:0] rd_data_q,  rd_data_d;

    // Sample storage, deliberately without reset (cleared by the sweep)
    logic [DataWidth-1:0]          mem_q [Depth];

    // Combinational control
    logic                          wr_en_s;
    logic                          rd_fire_s;
    logic                          ram_we_s;
    logic [AddrWidth-1:0]          ram_waddr_s;
    logic [DataWidth-1:0]          ram_wdata_s;
    logic [AddrWidth-1:0]          rd_base_s;
    logic [NumPorts*DataWidth-1:0] rd_word_s;

    // Next-state logic: sweep/run sequencing, write pointer and fill level
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        wr_en_s     = 1'b0;
        rd_fire_s   = 1'b0;
        ram_we_s    = 1'b0;
        ram_waddr_s = wr_ptr_q;
        ram_wdata_s = in_data_i;

        if (clear_i) begin
            // Flush wins over everything in this cycle: no write, no read.
            state_d   = StClr;
            clr_cnt_d = '0;
            wr_ptr_d  = '0;
            fill_d    = '0;
        end else begin
            case (state_q)
                StClr: begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = clr_cnt_q;
                    ram_wdata_s = '0;
                    wr_ptr_d    = '0;
                    fill_d      = '0;
                    if (clr_cnt_q == AddrLast) begin
                        state_d   = StRun;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + AddrOne;
                    end
                end
                StRun: begin
                    wr_en_s   = in_valid_i && in_ready_q;
                    rd_fire_s = rd_req_i;
                    if (wr_en_s) begin
                        ram_we_s = 1'b1;
                        // Pointer wraps naturally at Depth.
                        wr_ptr_d = wr_ptr_q + AddrOne;
                        if (fill_q == FillMax) begin
                            fill_d = fill_q;
                        end else begin
                            fill_d = fill_q + FillOne;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q;
                        fill_d   = fill_q;
                    end
                end
                default: begin
                    state_d   = StClr;
                    clr_cnt_d = '0;
                    wr_ptr_d  = '0;
                    fill_d    = '0;
                end
            endcase
        end

        in_ready_d = (state_d == StRun);
        full_d     = (fill_d == FillMax);
        rd_valid_d = rd_fire_s;
    end

    // Read address generation and read-register next value
    always_comb begin
        logic [AddrWidth-1:0] addr_v;
        logic [AddrWidth-1:0] off_v;

`ifdef SAMPLES_RING_BUF_WR_FWD_EN
        // In a write cycle, offsets are taken from the sample being written.
        rd_base_s = wr_en_s ? wr_ptr_q : (wr_ptr_q - AddrOne);
`else
        // Pre-write pointer: offset 0 is the newest sample already stored.
        rd_base_s = wr_ptr_q - AddrOne;
`endif
        rd_word_s = '0;
        addr_v    = '0;
        off_v     = '0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            off_v  = rd_offset_i[p*AddrWidth +: AddrWidth];
            addr_v = rd_base_s - off_v;
`ifdef SAMPLES_RING_BUF_WR_FWD_EN
            // Offset 0 targets the slot being written; bypass the array.
            rd_word_s[p*DataWidth +: DataWidth] =
                (wr_en_s && (off_v == '0)) ? in_data_i : mem_q[addr_v];
`else
            rd_word_s[p*DataWidth +: DataWidth] = mem_q[addr_v];
`endif
        end

        // Read register holds its last value between requests.
        rd_data_d = rd_fire_s ? rd_word_s : rd_data_q;
    end

    // Control and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StClr;
            clr_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            full_q     <= 1'b0;
            in_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            full_q     <= full_d;
            in_ready_q <= in_ready_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Storage write port (sweep zeros or accepted samples)
    always_ff @(posedge clk_i) begin
        if (ram_we_s) begin
            mem_q[ram_waddr_s] <= ram_wdata_s;
        end
    end

    assign in_ready_o = in_ready_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign fill_o     = fill_q;
    assign full_o     = full_q;

endmodule

// File: tb/tb_samples_ring_buf_nmult.sv
// -----------------------------------------------------------------------------
// tb_samples_ring_buf_nmult
//
// Directed bench for samples_ring_buf_nmult with DataWidth=18, AddrWidth=3
// (Depth 8) and NumPorts=2. Expected values are hand-derived constants.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_samples_ring_buf_nmult;

    localparam int DW = 18;
    localparam int AW = 3;
    localparam int NP = 2;

    logic              clk_i;
    logic              rst_ni;
    logic              clear_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DW-1:0]     in_data_i;
    logic              rd_req_i;
    logic [NP*AW-1:0]  rd_offset_i;
    logic              rd_valid_o;
    logic [NP*DW-1:0]  rd_data_o;
    logic [AW:0]       fill_o;
    logic              full_o;

    int check_cnt;
    int err_cnt;

    samples_ring_buf_nmult #(
        .DataWidth (DW),
        .AddrWidth (AW),
        .NumPorts  (NP)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .rd_req_i    (rd_req_i),
        .rd_offset_i (rd_offset_i),
        .rd_valid_o  (rd_valid_o),
        .rd_data_o   (rd_data_o),
        .fill_o      (fill_o),
        .full_o      (full_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_sample(input logic [DW-1:0] d);
        in_valid_i = 1'b1;
        in_data_i  = d;
        tick();
        in_valid_i = 1'b0;
        in_data_i  = '0;
    endtask

    task automatic read_ports(input logic [AW-1:0] o0, input logic [AW-1:0] o1);
        rd_req_i    = 1'b1;
        rd_offset_i = {o1, o0};
        tick();
        rd_req_i    = 1'b0;
        rd_offset_i = '0;
    endtask

    // Counts edges until in_ready_o rises, bounded; also records rd_valid_o.
    task automatic wait_ready(output int n, output logic saw_valid);
        n = 0;
        saw_valid = 1'b0;
        while ((in_ready_o !== 1'b1) && (n < 20)) begin
            tick();
            n++;
            if (rd_valid_o === 1'b1) saw_valid = 1'b1;
        end
    endtask

    initial begin
        int   n;
        logic sv;
        logic [DW-1:0] neg_v;

        check_cnt   = 0;
        err_cnt     = 0;
        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        rd_req_i    = 1'b0;
        rd_offset_i = '0;
        neg_v       = 18'h20000;

        tick();
        tick();
        check_val("rst_ready", 64'(in_ready_o), 64'd0);
        check_val("rst_valid", 64'(rd_valid_o), 64'd0);
        check_val("rst_data",  64'(rd_data_o),  64'd0);
        check_val("rst_fill",  64'(fill_o),     64'd0);
        check_val("rst_full",  64'(full_o),     64'd0);

        // Release reset, request reads throughout the sweep.
        rst_ni   = 1'b1;
        rd_req_i = 1'b1;
        wait_ready(n, sv);
        rd_req_i = 1'b0;
        check_val("sweep_len",      64'(n),  64'd8);
        check_val("sweep_no_valid", 64'(sv), 64'd0);
        check_val("sweep_fill",     64'(fill_o), 64'd0);

        // Five samples, read newest and oldest.
        for (int i = 1; i <= 5; i++) write_sample(DW'(i));
        read_ports(3'd0, 3'd4);
        check_val("rd5_valid", 64'(rd_valid_o), 64'd1);
        check_val("rd5_data",  64'(rd_data_o),  64'({18'd1, 18'd5}));
        check_val("rd5_fill",  64'(fill_o),     64'd5);
        check_val("rd5_full",  64'(full_o),     64'd0);
        tick();
        check_val("rd_pulse",  64'(rd_valid_o), 64'd0);
        check_val("rd_hold",   64'(rd_data_o),  64'({18'd1, 18'd5}));

        // Continue to 10 samples: wrap, full.
        for (int i = 6; i <= 10; i++) write_sample(DW'(i));
        check_val("wrap_fill", 64'(fill_o), 64'd8);
        check_val("wrap_full", 64'(full_o), 64'd1);
        read_ports(3'd0, 3'd7);
        check_val("wrap_0_7",  64'(rd_data_o), 64'({18'd3, 18'd10}));
        read_ports(3'd3, 3'd3);
        check_val("wrap_3_3",  64'(rd_data_o), 64'({18'd7, 18'd7}));

        // Same-cycle write of 11 and read {0,7}.
        in_valid_i  = 1'b1;
        in_data_i   = 18'd11;
        rd_req_i    = 1'b1;
        rd_offset_i = {3'd7, 3'd0};
        tick();
        in_valid_i  = 1'b0;
        rd_req_i    = 1'b0;
        rd_offset_i = '0;
        check_val("rw_valid", 64'(rd_valid_o), 64'd1);
`ifdef SAMPLES_RING_BUF_WR_FWD_EN
        check_val("rw_data",  64'(rd_data_o),  64'({18'd4, 18'd11}));
`else
        check_val("rw_data",  64'(rd_data_o),  64'({18'd3, 18'd10}));
`endif
        check_val("rw_fill",  64'(fill_o),     64'd8);
        read_ports(3'd0, 3'd1);
        check_val("post_rw",  64'(rd_data_o),  64'({18'd10, 18'd11}));

        // Clear with a same-cycle write and read that must be dropped.
        clear_i    = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = 18'd99;
        rd_req_i   = 1'b1;
        tick();
        clear_i    = 1'b0;
        in_valid_i = 1'b0;
        rd_req_i   = 1'b0;
        check_val("clr_no_valid", 64'(rd_valid_o), 64'd0);
        check_val("clr_ready",    64'(in_ready_o), 64'd0);
        check_val("clr_fill",     64'(fill_o),     64'd0);
        check_val("clr_full",     64'(full_o),     64'd0);
        wait_ready(n, sv);
        check_val("clr_sweep_len", 64'(n), 64'd8);
        read_ports(3'd0, 3'd1);
        check_val("clr_zero",      64'(rd_data_o), 64'd0);
        check_val("clr_fill_run",  64'(fill_o),    64'd0);

        // Most-negative sample round-trips bit-exact.
        write_sample(neg_v);
        read_ports(3'd0, 3'd0);
        check_val("neg_data", 64'(rd_data_o), 64'({18'h20000, 18'h20000}));
        check_val("neg_fill", 64'(fill_o),    64'd1);

        // Reset in the middle of a sweep.
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        tick();
        tick();
        tick();
        rst_ni = 1'b0;
        #1;
        check_val("mid_rst_ready", 64'(in_ready_o), 64'd0);
        check_val("mid_rst_data",  64'(rd_data_o),  64'd0);
        check_val("mid_rst_fill",  64'(fill_o),     64'd0);
        tick();
        rst_ni = 1'b1;
        wait_ready(n, sv);
        check_val("mid_rst_sweep", 64'(n), 64'd8);
        read_ports(3'd0, 3'd7);
        check_val("mid_rst_zero",  64'(rd_data_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
